// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and IR registers, runs the req/ack
// handshake to instruction memory with a bounded wait, and decodes the
// registered instruction into its fields and a sign-extended immediate.
module instr_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_start,
    input  logic            pc_write,
    input  logic [XLEN-1:0] pc_wdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic            busy,
    output logic            ir_valid,
    output logic            fetch_fault,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm
);

    // Wait counter only needs to reach MAX_WAIT-1.
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] addr_r, addr_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [31:0]     instr_r, instr_nxt_s;
    logic            ir_valid_r, ir_valid_nxt_s;
    logic            fault_r, fault_nxt_s;

    // Immediate extraction; opcode 1100111 with func3=001 is the local bne
    // encoding and therefore uses the B-type layout instead of I-type.
    function automatic logic [XLEN-1:0] imm_sel(input logic [31:0] i);
        logic [XLEN-1:0] i_imm;
        logic [XLEN-1:0] s_imm;
        logic [XLEN-1:0] b_imm;
        logic [XLEN-1:0] u_imm;
        logic [XLEN-1:0] j_imm;
        logic [XLEN-1:0] res;
        i_imm = {{(XLEN-12){i[31]}}, i[31:20]};
        s_imm = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
        b_imm = {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        u_imm = {{(XLEN-32){i[31]}}, i[31:12], 12'b0000_0000_0000};
        j_imm = {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (i[6:0])
            OP_LOAD, OP_IMM: res = i_imm;
            OP_JALR: begin
                if (i[14:12] == 3'b001) begin
                    res = b_imm;
                end else begin
                    res = i_imm;
                end
            end
            OP_STORE:         res = s_imm;
            OP_BRANCH:        res = b_imm;
            OP_LUI, OP_AUIPC: res = u_imm;
            OP_JAL:           res = j_imm;
            default:          res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // Next-state and next-register values for the fetch handshake.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        cnt_nxt_s      = cnt_r;
        instr_nxt_s    = instr_r;
        ir_valid_nxt_s = 1'b0;
        fault_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (fetch_start) begin
                    addr_nxt_s  = pc_r;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_nxt_s    = imem_rdata;
                    ir_valid_nxt_s = 1'b1;
                    state_nxt_s    = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    fault_nxt_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Fetch state, latched address, wait counter, IR and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            addr_r     <= RESET_PC;
            cnt_r      <= {CW{1'b0}};
            instr_r    <= NOP;
            ir_valid_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            instr_r    <= instr_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            fault_r    <= fault_nxt_s;
        end
    end

    // PC register: loaded in any state, independent of an in-flight fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else if (pc_write) begin
            pc_r <= pc_wdata;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign imem_req    = (state_r == REQ);
    assign busy        = (state_r == REQ);
    assign imem_addr   = addr_r;
    assign pc          = pc_r;
    assign ir_valid    = ir_valid_r;
    assign fetch_fault = fault_r;
    assign instr       = instr_r;

    // Decode strictly from the IR register so fields only move on ir_valid.
    assign opcode = instr_r[6:0];
    assign rd     = instr_r[11:7];
    assign func3  = instr_r[14:12];
    assign rs1    = instr_r[19:15];
    assign rs2    = instr_r[24:20];
    assign func7  = instr_r[31:25];
    assign imm    = imm_sel(instr_r);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            fetch_start = 1'b0;
    logic            pc_write = 1'b0;
    logic [XLEN-1:0] pc_wdata = '0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            imem_ack = 1'b0;
    logic [XLEN-1:0] pc;
    logic            busy;
    logic            ir_valid;
    logic            fetch_fault;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start),
        .pc_write(pc_write), .pc_wdata(pc_wdata), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .pc(pc), .busy(busy), .ir_valid(ir_valid), .fetch_fault(fetch_fault),
        .instr(instr), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1),
        .rs2(rs2), .func7(func7), .imm(imm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle fetch: start, then ack with the given word immediately.
    task automatic do_fetch(input logic [31:0] word);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = word;
        tick();
        imem_ack    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h0); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h13); end
        checks++; if ({imem_req, busy, ir_valid, fetch_fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {imem_req, busy, ir_valid, fetch_fault}); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if ({imem_req, busy} !== 2'b11) begin errors++; $display("FAIL basic_req: got %b expected 11", {imem_req, busy}); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL basic_addr: got %h expected 0", imem_addr); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL basic_ir_early: got %h expected 13", instr); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checks++; if ({ir_valid, imem_req, fetch_fault} !== 3'b100) begin errors++; $display("FAIL basic_valid: got %b expected 100", {ir_valid, imem_req, fetch_fault}); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL basic_instr: got %h expected 00a00093", instr); end
        checks++; if ({opcode, rd, func3, rs1} !== {7'h13, 5'd1, 3'd0, 5'd0}) begin errors++; $display("FAIL basic_fields: got %h/%0d/%0d/%0d expected 13/1/0/0", opcode, rd, func3, rs1); end
        checks++; if (imm !== 64'd10) begin errors++; $display("FAIL basic_imm: got %h expected a", imm); end
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", ir_valid); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL basic_ir_hold: got %h expected 00a00093 (not rdata)", instr); end
    endtask

    task automatic test_wait_states();
        int bad = 0;
        int pulses = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({imem_req, busy} !== 2'b11 || imem_addr !== 64'h0 || ir_valid !== 1'b0) bad++;
            tick();
        end
        if ({imem_req, busy} !== 2'b11 || imem_addr !== 64'h0) bad++;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFF0_0093;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ir_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wait_stable: got %0d bad cycles expected 0", bad); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wait_pulses: got %0d expected 1", pulses); end
        checks++; if (imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wait_imm: got %h expected all ones", imm); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int early_fault = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        while (imem_req === 1'b1 && n < 40) begin
            if (fetch_fault !== 1'b0 || ir_valid !== 1'b0) early_fault++;
            n++;
            tick();
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 15", n); end
        checks++; if ({fetch_fault, ir_valid, busy} !== 3'b100) begin errors++; $display("FAIL timeout_fault: got %b expected 100", {fetch_fault, ir_valid, busy}); end
        checks++; if (early_fault !== 0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", early_fault); end
        checks++; if (instr !== 32'hFFF0_0093) begin errors++; $display("FAIL timeout_instr: got %h expected fff00093", instr); end
        tick();
        checks++; if ({fetch_fault, imem_req} !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b expected 00", {fetch_fault, imem_req}); end
        // A second fetch after the abort must work normally.
        do_fetch(32'h0000_0013);
        checks++; if ({ir_valid, instr} !== {1'b1, 32'h0000_0013}) begin errors++; $display("FAIL timeout_recover: got %b/%h expected 1/00000013", ir_valid, instr); end
    endtask

    task automatic test_immediates();
        logic [31:0] words [9];
        logic [63:0] exps  [9];
        words[0] = 32'hFE00_0EE3; exps[0] = 64'hFFFF_FFFF_FFFF_FFFC; // beq -4
        words[1] = 32'h1234_52B7; exps[1] = 64'h0000_0000_1234_5000; // lui
        words[2] = 32'h00B5_3023; exps[2] = 64'h0;                   // sd 0(a0)
        words[3] = 32'hFE00_1EE7; exps[3] = 64'hFFFF_FFFF_FFFF_FFFC; // local bne
        words[4] = 32'h00C0_8067; exps[4] = 64'd12;                  // jalr 12
        words[5] = 32'h0080_00EF; exps[5] = 64'd8;                   // jal 8
        words[6] = 32'hFFFF_F117; exps[6] = 64'hFFFF_FFFF_FFFF_F000; // auipc
        words[7] = 32'h00B5_0533; exps[7] = 64'h0;                   // add (R)
        words[8] = 32'hFE11_3C23; exps[8] = 64'hFFFF_FFFF_FFFF_FFF8; // sd -8(sp)
        for (int i = 0; i < 9; i++) begin
            do_fetch(words[i]);
            checks++; if (imm !== exps[i]) begin errors++; $display("FAIL imm_%0d: got %h expected %h", i, imm, exps[i]); end
        end
        do_fetch(32'h00B5_3023);
        checks++; if ({func3, rs1, rs2, func7} !== {3'd3, 5'd10, 5'd11, 7'd0}) begin errors++; $display("FAIL sd_fields: got %0d/%0d/%0d/%0d expected 3/10/11/0", func3, rs1, rs2, func7); end
    endtask

    task automatic test_pc_write();
        pc_write = 1'b1;
        pc_wdata = 64'h8;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 64'h8) begin errors++; $display("FAIL pcw_load: got %h expected 8", pc); end
        fetch_start = 1'b1;
        pc_write    = 1'b1;
        pc_wdata    = 64'h40;
        tick();
        pc_write    = 1'b0;
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL pcw_addr_old: got %h expected 8", imem_addr); end
        checks++; if (pc !== 64'h40) begin errors++; $display("FAIL pcw_pc_new: got %h expected 40", pc); end
        // fetch_start held during REQ plus a PC change mid-fetch.
        pc_write = 1'b1;
        pc_wdata = 64'h100;
        tick();
        pc_write    = 1'b0;
        fetch_start = 1'b0;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 64'h8}) begin errors++; $display("FAIL pcw_inflight: got %b/%h expected 1/8", imem_req, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0513;
        tick();
        imem_ack = 1'b0;
        checks++; if ({ir_valid, imem_req, pc} !== {2'b10, 64'h100}) begin errors++; $display("FAIL pcw_done: got %b/%b/%h expected 1/0/100", ir_valid, imem_req, pc); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pcw_no_queue: got %b expected 0", imem_req); end
    endtask

    task automatic test_reset_mid_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", imem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({imem_req, busy} !== 2'b00) begin errors++; $display("FAIL rst_async_req: got %b expected 00", {imem_req, busy}); end
        checks++; if ({instr, pc} !== {32'h0000_0013, 64'h0}) begin errors++; $display("FAIL rst_async_state: got %h/%h expected 13/0", instr, pc); end
        reset_n = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_52B7;
        tick();
        imem_ack = 1'b0;
        checks++; if ({ir_valid, instr} !== {1'b0, 32'h0000_0013}) begin errors++; $display("FAIL rst_ack_ignored: got %b/%h expected 0/00000013", ir_valid, instr); end
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %b expected 0", ir_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_timeout();
        test_immediates();
        test_pc_write();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
